alu_seq: RTL and testbench

Multi-cycle sequencer wrapped around the 8-bit `ALU` datapath. It accepts one command at a time over a valid/ready handshake and holds the accumulator as `op1`. It applies the selected ALU operation 1–8 times back to back, with the command operand as `op2`, and maintains 8085-style S/Z/P/CY flags. The result is returned over a second valid/ready handshake. It sits between instruction decode and the `ALU` instance; repeated application provides multiply-by-repeated-add and multi-bit rotates.

---
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_seq.sv | 104 ++++++++++
 tb/tb_alu_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Command/response bundle for alu_seq: decode-side master, sequencer-side slave.
interface alu_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [2:0] cmd_cnt;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] acc;
  logic [3:0] flags;
  logic       busy;

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_data, cmd_cnt, rsp_ready,
    input  cmd_ready, rsp_valid, acc, flags, busy
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_data, cmd_cnt, rsp_ready,
    output cmd_ready, rsp_valid, acc, flags, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle sequencer around an 8-bit ALU: applies one op 1..8 times to the
// accumulator and keeps 8085-style {S,Z,P,CY} flags.
module alu_seq #(
  parameter logic [7:0] RESET_ACC = 8'h00
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] data_q, data_d;
  logic [3:0] flags_q, flags_d;
  logic [2:0] op_q, op_d;
  logic [2:0] rem_q, rem_d;

  logic [8:0] sum;
  logic [7:0] alu_r;
  logic       cy;
  logic       szp_upd;
  logic       cy_upd;

  // ALU datapath; carry/borrow is derived here since the ALU itself is 8-bit only
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, data_q};
    alu_r   = '0;
    cy      = 1'b0;
    szp_upd = 1'b0;
    cy_upd  = 1'b0;
    case (op_q)
      3'b000: begin alu_r = sum[7:0];            cy = sum[8];         szp_upd = 1'b1; cy_upd = 1'b1; end
      3'b001: begin alu_r = acc_q - data_q;      cy = acc_q < data_q; szp_upd = 1'b1; cy_upd = 1'b1; end
      3'b010: begin alu_r = {acc_q[6:0], acc_q[7]}; cy = acc_q[7];    cy_upd = 1'b1; end
      3'b011: begin alu_r = {acc_q[0], acc_q[7:1]}; cy = acc_q[0];    cy_upd = 1'b1; end
      3'b100: begin alu_r = acc_q & data_q;      szp_upd = 1'b1; cy_upd = 1'b1; end
      3'b101: begin alu_r = acc_q | data_q;      szp_upd = 1'b1; cy_upd = 1'b1; end
      3'b110: begin alu_r = acc_q ^ data_q;      szp_upd = 1'b1; cy_upd = 1'b1; end
      default: alu_r = ~acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    data_d  = data_q;
    flags_d = flags_q;
    op_d    = op_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          data_d = bus.cmd_data;
          rem_d  = bus.cmd_cnt;
          if (bus.cmd_load) begin
            acc_d   = bus.cmd_data;
            state_d = RESP;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        acc_d = alu_r;
        if (szp_upd) flags_d[3:1] = {alu_r[7], alu_r == 8'h00, ~^alu_r};
        if (cy_upd)  flags_d[0]   = cy;
        if (rem_q == 3'd0) state_d = RESP;
        else               rem_d   = rem_q - 3'd1;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= RESET_ACC;
      data_q  <= '0;
      flags_q <= '0;
      op_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE);
  assign bus.acc       = acc_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with hand-computed accumulator/flag expectations.
module tb_alu_seq;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  alu_seq_if bus();

  alu_seq #(.RESET_ACC(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic load, input logic [2:0] op, input logic [7:0] data,
                      input logic [2:0] cnt);
    bus.cmd_load  = load;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_cnt   = cnt;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!bus.rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input logic load, input logic [2:0] op,
                        input logic [7:0] data, input logic [2:0] cnt,
                        input logic [7:0] exp_acc, input logic [3:0] exp_flags);
    int cyc;
    send(load, op, data, cnt);
    wait_rsp(cyc);
    check({tag, "_lat"}, 16'(cyc), load ? 16'd0 : 16'(cnt) + 16'd1);
    check({tag, "_acc"}, {8'h00, bus.acc}, {8'h00, exp_acc});
    check({tag, "_flags"}, {12'h000, bus.flags}, {12'h000, exp_flags});
    take_rsp();
    check({tag, "_ready"}, {15'h0, bus.cmd_ready}, 16'd1);
  endtask

  initial begin
    int cyc;
    logic [7:0] rot_exp [3];
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_data  = 8'h00;
    bus.cmd_cnt   = 3'd0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc",   {8'h00, bus.acc}, 16'h00A5);
    check("rst_flags", {12'h000, bus.flags}, 16'h0000);
    check("rst_busy",  {15'h0, bus.busy}, 16'd0);
    check("rst_rspv",  {15'h0, bus.rsp_valid}, 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", {15'h0, bus.cmd_ready}, 16'd1);

    do_cmd("ld3c",   1'b1, 3'b000, 8'h3C, 3'd0, 8'h3C, 4'b0000);
    do_cmd("addc8",  1'b0, 3'b000, 8'hC8, 3'd0, 8'h04, 4'b0001);

    do_cmd("ld81",   1'b1, 3'b000, 8'h81, 3'd0, 8'h81, 4'b0001);
    rot_exp[0] = 8'h03; rot_exp[1] = 8'h06; rot_exp[2] = 8'h0C;
    send(1'b0, 3'b010, 8'h00, 3'd2);
    check("rol_busy", {15'h0, bus.cmd_ready}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rol_step", {8'h00, bus.acc}, {8'h00, rot_exp[i]});
    end
    check("rol_rspv",  {15'h0, bus.rsp_valid}, 16'd1);
    check("rol_flags", {12'h000, bus.flags}, 16'h0000);
    take_rsp();

    do_cmd("ld00",   1'b1, 3'b000, 8'h00, 3'd0, 8'h00, 4'b0000);
    do_cmd("add7x8", 1'b0, 3'b000, 8'h07, 3'd7, 8'h38, 4'b0000);

    do_cmd("ld05",   1'b1, 3'b000, 8'h05, 3'd0, 8'h05, 4'b0000);
    do_cmd("sub05",  1'b0, 3'b001, 8'h05, 3'd0, 8'h00, 4'b0110);
    do_cmd("sub01",  1'b0, 3'b001, 8'h01, 3'd0, 8'hFF, 4'b1011);
    do_cmd("not",    1'b0, 3'b111, 8'h00, 3'd0, 8'h00, 4'b1011);

    do_cmd("ld02",   1'b1, 3'b000, 8'h02, 3'd0, 8'h02, 4'b1011);
    do_cmd("ror2",   1'b0, 3'b011, 8'h00, 3'd1, 8'h80, 4'b1011);
    do_cmd("ldf0",   1'b1, 3'b000, 8'hF0, 3'd0, 8'hF0, 4'b1011);
    do_cmd("and3c",  1'b0, 3'b100, 8'h3C, 3'd0, 8'h30, 4'b0010);
    do_cmd("or0f",   1'b0, 3'b101, 8'h0F, 3'd0, 8'h3F, 4'b0010);
    do_cmd("xor3f",  1'b0, 3'b110, 8'h3F, 3'd0, 8'h00, 4'b0110);

    // Stall in RESP with a pending command that must not be taken
    send(1'b0, 3'b000, 8'h01, 3'd0);
    wait_rsp(cyc);
    check("stall_lat", 16'(cyc), 16'd1);
    bus.cmd_load  = 1'b1;
    bus.cmd_data  = 8'h55;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_ready", {15'h0, bus.cmd_ready}, 16'd0);
    end
    check("stall_acc",   {8'h00, bus.acc}, 16'h0001);
    check("stall_flags", {12'h000, bus.flags}, 16'h0000);
    check("stall_rspv",  {15'h0, bus.rsp_valid}, 16'd1);
    take_rsp();
    check("rel_ready", {15'h0, bus.cmd_ready}, 16'd1);
    check("rel_rspv",  {15'h0, bus.rsp_valid}, 16'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("rel_take_rspv", {15'h0, bus.rsp_valid}, 16'd1);
    check("rel_take_acc",  {8'h00, bus.acc}, 16'h0055);
    take_rsp();

    // Asynchronous reset in the middle of an 8-iteration add
    send(1'b0, 3'b000, 8'h01, 3'd7);
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", {15'h0, bus.busy}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc",   {8'h00, bus.acc}, 16'h00A5);
    check("arst_flags", {12'h000, bus.flags}, 16'h0000);
    check("arst_busy",  {15'h0, bus.busy}, 16'd0);
    check("arst_rspv",  {15'h0, bus.rsp_valid}, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rspv",  {15'h0, bus.rsp_valid}, 16'd0);
    check("post_ready", {15'h0, bus.cmd_ready}, 16'd1);
    check("post_acc",   {8'h00, bus.acc}, 16'h00A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
